// File: rtl/cache_controller_if.sv
// CPU request/response bus and main_memory block port of the cache controller.
// The master modport is the CPU/memory side; the slave modport is the controller.
interface cache_controller_if #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_BYTES = 32
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [ADDR_W-1:0]        cpu_addr;
    logic [31:0]              cpu_wdata;
    logic [31:0]              cpu_rdata;
    logic                     cpu_ready;
    logic                     mem_read_en;
    logic                     mem_write_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic [8*BLOCK_BYTES-1:0] mem_write_block;
    logic [8*BLOCK_BYTES-1:0] mem_read_block;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_read_block,
        input  cpu_rdata, cpu_ready, mem_read_en, mem_write_en, mem_addr, mem_write_block
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_read_block,
        output cpu_rdata, cpu_ready, mem_read_en, mem_write_en, mem_addr, mem_write_block
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache for 32-bit word accesses.
// Misses move whole blocks to/from main_memory; dirty victims are written back before refill.
module cache_controller #(
    parameter int MEM_BYTES   = 65536,
    parameter int BLOCK_BYTES = 32,
    parameter int NUM_LINES   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_controller_if.slave  bus
);
    localparam int ADDR_W = $clog2(MEM_BYTES);
    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;
    localparam int LINE_W = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [TAG_W-1:0]    r_req_tag;
    logic [IDX_W-1:0]    r_req_idx;
    logic [WORD_W-1:0]   r_req_word;
    logic                r_req_we;
    logic [31:0]         r_req_wdata;

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag  [NUM_LINES];
    logic [LINE_W-1:0]   r_line [NUM_LINES];

    logic                r_ready;
    logic [31:0]         r_rdata;

    logic                w_hit;
    logic                w_victim_dirty;
    logic [LINE_W-1:0]   w_line;
    logic [TAG_W-1:0]    w_old_tag;
    logic [OFF_W+2:0]    w_bit_sel;
    logic                w_mem_rd;
    logic                w_mem_wr;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [LINE_W-1:0]   w_mem_wblk;

    assign w_line         = r_line[r_req_idx];
    assign w_old_tag      = r_tag[r_req_idx];
    assign w_hit          = r_valid[r_req_idx] && (w_old_tag == r_req_tag);
    assign w_victim_dirty = r_valid[r_req_idx] && r_dirty[r_req_idx];
    assign w_bit_sel      = {r_req_word, 5'd0};

    always_comb begin
        w_next     = r_state;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_mem_addr = '0;
        w_mem_wblk = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (w_hit)               w_next = S_IDLE;
                else if (w_victim_dirty) w_next = S_WRITEBACK;
                else                     w_next = S_ALLOCATE;
            end
            S_WRITEBACK: begin
                w_mem_wr   = 1'b1;
                w_mem_addr = {w_old_tag, r_req_idx, {OFF_W{1'b0}}};
                w_mem_wblk = w_line;
                w_next     = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = {r_req_tag, r_req_idx, {OFF_W{1'b0}}};
                w_next     = S_COMPARE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control state: FSM, line status bits and the CPU response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= 1'b0;
            if (r_state == S_COMPARE && w_hit) begin
                r_ready <= 1'b1;
                if (r_req_we) r_dirty[r_req_idx] <= 1'b1;
                else          r_rdata <= w_line[w_bit_sel +: 32];
            end
            if (r_state == S_ALLOCATE) begin
                r_valid[r_req_idx] <= 1'b1;
                r_dirty[r_req_idx] <= 1'b0;
            end
        end
    end

    // Request fields, tags and line data carry no reset; valid bits guard their use.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.cpu_req) begin
            r_req_tag   <= bus.cpu_addr[ADDR_W-1 -: TAG_W];
            r_req_idx   <= bus.cpu_addr[OFF_W +: IDX_W];
            r_req_word  <= bus.cpu_addr[2 +: WORD_W];
            r_req_we    <= bus.cpu_we;
            r_req_wdata <= bus.cpu_wdata;
        end
        if (r_state == S_COMPARE && w_hit && r_req_we)
            r_line[r_req_idx][w_bit_sel +: 32] <= r_req_wdata;
        if (r_state == S_ALLOCATE) begin
            r_line[r_req_idx] <= bus.mem_read_block;
            r_tag[r_req_idx]  <= r_req_tag;
        end
    end

    assign bus.cpu_ready       = r_ready;
    assign bus.cpu_rdata       = r_rdata;
    assign bus.mem_read_en     = w_mem_rd;
    assign bus.mem_write_en    = w_mem_wr;
    assign bus.mem_addr        = w_mem_addr;
    assign bus.mem_write_block = w_mem_wblk;
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: behavioural main_memory plus a word-level
// reference model predicting hit/miss latency, memory traffic and read data.
module tb_cache_controller;
    localparam int MEM_BYTES   = 65536;
    localparam int BLOCK_BYTES = 32;
    localparam int NUM_LINES   = 8;
    localparam int ADDR_W      = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if #(.ADDR_W(ADDR_W), .BLOCK_BYTES(BLOCK_BYTES)) bus ();

    cache_controller #(.MEM_BYTES(MEM_BYTES), .BLOCK_BYTES(BLOCK_BYTES), .NUM_LINES(NUM_LINES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Backing store: combinational block read, block write committed at the clock edge.
    logic [7:0] mem [MEM_BYTES];
    logic       mem_init = 1'b0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'($urandom);
            mem[16'h0040] <= 8'hEF;
            mem[16'h0041] <= 8'hBE;
            mem[16'h0042] <= 8'hAD;
            mem[16'h0043] <= 8'hDE;
        end else if (bus.mem_write_en) begin
            for (int i = 0; i < BLOCK_BYTES; i++)
                mem[int'(bus.mem_addr) + i] <= bus.mem_write_block[i*8 +: 8];
        end
    end

    always_comb begin
        bus.mem_read_block = '0;
        if (bus.mem_read_en)
            for (int i = 0; i < BLOCK_BYTES; i++)
                bus.mem_read_block[i*8 +: 8] = mem[int'(bus.mem_addr) + i];
    end

    // Reference model: CPU-visible byte image plus which block each index holds.
    logic [7:0] ref_mem [MEM_BYTES];
    bit         m_valid [NUM_LINES];
    bit         m_dirty [NUM_LINES];
    int         m_tag   [NUM_LINES];
    logic [31:0] last_rd;

    typedef struct {
        int lat;
        int nrd;
        int nwr;
        int rd_addr;
        int wr_addr;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        int          rd_addr;
        int          wr_addr;
        bit          timeout;
    } obs_t;

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic exp_t predict(input int a);
        exp_t e;
        int   idx;
        int   tag;
        idx = (a >> 5) & 7;
        tag = (a >> 8) & 255;
        e = '{default: 0};
        if (m_valid[idx] && m_tag[idx] == tag) begin
            e.lat = 1;
        end else if (m_valid[idx] && m_dirty[idx]) begin
            e.lat = 4; e.nrd = 1; e.nwr = 1;
            e.wr_addr = (m_tag[idx] << 8) | (idx << 5);
            e.rd_addr = a & ~31;
        end else begin
            e.lat = 3; e.nrd = 1;
            e.rd_addr = a & ~31;
        end
        return e;
    endfunction

    task automatic model_apply(input int a, input bit we, input logic [31:0] d);
        int idx;
        int tag;
        int b;
        idx = (a >> 5) & 7;
        tag = (a >> 8) & 255;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_dirty[idx] = 1'b1;
            b = a & ~3;
            for (int i = 0; i < 4; i++) ref_mem[b+i] = d[i*8 +: 8];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        last_rd = 32'h0;
    endtask

    // Issues one request (called #1 after an edge with the DUT idle) and records what it did.
    task automatic access(input int a, input bit we, input logic [31:0] d, output obs_t o);
        o = '{default: 0};
        o.timeout = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 16'(a);
        bus.cpu_we    = we;
        bus.cpu_wdata = d;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.mem_read_en)  begin o.nrd++; o.rd_addr = int'(bus.mem_addr); end
            if (bus.mem_write_en) begin o.nwr++; o.wr_addr = int'(bus.mem_addr); end
            if (bus.cpu_ready) begin
                o.lat = k; o.rdata = bus.cpu_rdata; o.timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        rst_n = 1'b0;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.cpu_ready); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.cpu_rdata); end
        checks++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b00) begin errors++; $display("FAIL reset_mem_en got %b want 00", {bus.mem_read_en, bus.mem_write_en}); end
        checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++; if ({bus.cpu_ready, bus.mem_read_en, bus.mem_write_en} !== 3'b000) begin errors++; $display("FAIL post_reset_idle got %b want 000", {bus.cpu_ready, bus.mem_read_en, bus.mem_write_en}); end
    endtask

    task automatic test_clean_miss();
        obs_t o;
        access(32'h0040, 1'b0, 32'h0, o);
        checks++; if (o.timeout || o.lat !== 3) begin errors++; $display("FAIL clean_miss_latency got %0d (timeout %0b) want 3", o.lat, o.timeout); end
        checks++; if (o.nrd !== 1 || o.rd_addr !== 32'h40) begin errors++; $display("FAIL clean_miss_fill got %0d pulses @%h want 1 @0040", o.nrd, o.rd_addr); end
        checks++; if (o.nwr !== 0) begin errors++; $display("FAIL clean_miss_nowrite got %0d want 0", o.nwr); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL clean_miss_data got %h want deadbeef", o.rdata); end
        model_apply(32'h0040, 1'b0, 32'h0);
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_hit_read();
        obs_t        o;
        logic [31:0] exp_d;
        exp_d = {mem[16'h47], mem[16'h46], mem[16'h45], mem[16'h44]};
        access(32'h0044, 1'b0, 32'h0, o);
        checks++; if (o.timeout || o.lat !== 1) begin errors++; $display("FAIL hit_read_latency got %0d want 1", o.lat); end
        checks++; if (o.nrd + o.nwr !== 0) begin errors++; $display("FAIL hit_read_mem_activity got %0d pulses want 0", o.nrd + o.nwr); end
        checks++; if (o.rdata !== exp_d) begin errors++; $display("FAIL hit_read_data got %h want %h", o.rdata, exp_d); end
        last_rd = exp_d;
    endtask

    task automatic test_write_hit();
        obs_t       o;
        logic [7:0] old_b [4];
        for (int i = 0; i < 4; i++) old_b[i] = mem[16'h48 + i];
        access(32'h0048, 1'b1, 32'h12345678, o);
        checks++; if (o.timeout || o.lat !== 1) begin errors++; $display("FAIL write_hit_latency got %0d want 1", o.lat); end
        checks++; if (o.nrd + o.nwr !== 0) begin errors++; $display("FAIL write_hit_mem_activity got %0d want 0", o.nrd + o.nwr); end
        checks++; if (o.rdata !== last_rd) begin errors++; $display("FAIL write_hit_rdata_hold got %h want %h", o.rdata, last_rd); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[16'h48 + i] !== old_b[i]) begin errors++; $display("FAIL write_hit_mem_untouched byte %0d got %h want %h", i, mem[16'h48 + i], old_b[i]); end
        end
        model_apply(32'h0048, 1'b1, 32'h12345678);
        access(32'h0048, 1'b0, 32'h0, o);
        checks++; if (o.timeout || o.lat !== 1 || o.rdata !== 32'h12345678) begin errors++; $display("FAIL write_readback got %h lat %0d want 12345678 lat 1", o.rdata, o.lat); end
        last_rd = 32'h12345678;
    endtask

    task automatic test_dirty_miss();
        obs_t        o;
        logic [31:0] exp_d;
        int          bad;
        exp_d = {mem[16'h14B], mem[16'h14A], mem[16'h149], mem[16'h148]};
        access(32'h0148, 1'b0, 32'h0, o);
        checks++; if (o.timeout || o.lat !== 4) begin errors++; $display("FAIL dirty_miss_latency got %0d want 4", o.lat); end
        checks++; if (o.nwr !== 1 || o.wr_addr !== 32'h40) begin errors++; $display("FAIL dirty_miss_writeback got %0d @%h want 1 @0040", o.nwr, o.wr_addr); end
        checks++; if (o.nrd !== 1 || o.rd_addr !== 32'h140) begin errors++; $display("FAIL dirty_miss_fill got %0d @%h want 1 @0140", o.nrd, o.rd_addr); end
        checks++; if ({mem[16'h4B], mem[16'h4A], mem[16'h49], mem[16'h48]} !== 32'h12345678) begin errors++; $display("FAIL dirty_miss_mem_word got %h want 12345678", {mem[16'h4B], mem[16'h4A], mem[16'h49], mem[16'h48]}); end
        bad = 0;
        for (int i = 0; i < BLOCK_BYTES; i++) if (mem[16'h40 + i] !== ref_mem[16'h40 + i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL dirty_miss_victim_block got %0d wrong bytes want 0", bad); end
        checks++; if (o.rdata !== exp_d) begin errors++; $display("FAIL dirty_miss_data got %h want %h", o.rdata, exp_d); end
        model_apply(32'h0148, 1'b0, 32'h0);
        last_rd = exp_d;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        int   a;
        int   cyc;
        int   mem_act;
        e = predict(32'h0044);
        access(32'h0044, 1'b0, 32'h0, o);
        checks++; if (o.timeout || o.lat !== e.lat || o.nrd !== 1) begin errors++; $display("FAIL b2b_prime got lat %0d fills %0d want lat %0d fills 1", o.lat, o.nrd, e.lat); end
        model_apply(32'h0044, 1'b0, 32'h0);
        mem_act = 0;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 0) ? 32'h0044 : 32'h0048;
            bus.cpu_addr = 16'(a);
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
                if (bus.mem_read_en || bus.mem_write_en) mem_act++;
            end while (!bus.cpu_ready && cyc < 6);
            checks++; if (cyc !== 2) begin errors++; $display("FAIL b2b_spacing req %0d got %0d cycles want 2", i, cyc); end
            checks++; if (bus.cpu_rdata !== ref_word(a)) begin errors++; $display("FAIL b2b_data req %0d got %h want %h", i, bus.cpu_rdata, ref_word(a)); end
        end
        bus.cpu_req = 1'b0;
        last_rd = ref_word(32'h0048);
        checks++; if (mem_act !== 0) begin errors++; $display("FAIL b2b_mem_activity got %0d want 0", mem_act); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   seen;
        int   readies;
        seen = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0244;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.mem_read_en) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL reset_mid_reach_allocate got no fill want fill"); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_read_en, bus.mem_write_en, bus.cpu_ready} !== 3'b000) begin errors++; $display("FAIL reset_mid_outputs got %b want 000", {bus.mem_read_en, bus.mem_write_en, bus.cpu_ready}); end
        checks++; if (bus.cpu_rdata !== 32'h0 || bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mid_regs got rdata %h addr %h want 0", bus.cpu_rdata, bus.mem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        readies = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.cpu_ready || bus.mem_read_en) readies++;
        end
        checks++; if (readies !== 0) begin errors++; $display("FAIL reset_mid_dropped got %0d activity cycles want 0", readies); end
        access(32'h0044, 1'b0, 32'h0, o);
        checks++; if (o.timeout || o.lat !== 3 || o.nrd !== 1 || o.rd_addr !== 32'h40) begin errors++; $display("FAIL reset_mid_remiss got lat %0d fills %0d @%h want 3 1 @0040", o.lat, o.nrd, o.rd_addr); end
        checks++; if (o.rdata !== ref_word(32'h0044)) begin errors++; $display("FAIL reset_mid_data got %h want %h", o.rdata, ref_word(32'h0044)); end
        model_apply(32'h0044, 1'b0, 32'h0);
        last_rd = ref_word(32'h0044);
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        int          a;
        int          tag;
        int          bad;
        bit          we;
        logic [31:0] d;
        logic [31:0] exp_d;
        for (int n = 0; n < 80; n++) begin
            tag = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            a   = (tag << 8) | (int'($urandom_range(0, 7)) << 5) | (int'($urandom_range(0, 7)) << 2) | int'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            e   = predict(a);
            exp_d = we ? last_rd : ref_word(a);
            access(a, we, d, o);
            checks++; if (o.timeout || o.lat !== e.lat) begin errors++; $display("FAIL rand_latency addr %h got %0d want %0d", a, o.lat, e.lat); end
            checks++; if (o.nrd !== e.nrd || o.nwr !== e.nwr) begin errors++; $display("FAIL rand_traffic addr %h got rd %0d wr %0d want rd %0d wr %0d", a, o.nrd, o.nwr, e.nrd, e.nwr); end
            checks++; if ((e.nrd != 0 && o.rd_addr !== e.rd_addr) || (e.nwr != 0 && o.wr_addr !== e.wr_addr)) begin errors++; $display("FAIL rand_mem_addr addr %h got rd %h wr %h want rd %h wr %h", a, o.rd_addr, o.wr_addr, e.rd_addr, e.wr_addr); end
            checks++; if (o.rdata !== exp_d) begin errors++; $display("FAIL rand_rdata addr %h we %0b got %h want %h", a, we, o.rdata, exp_d); end
            if (e.nwr != 0) begin
                bad = 0;
                for (int i = 0; i < BLOCK_BYTES; i++) if (mem[e.wr_addr + i] !== ref_mem[e.wr_addr + i]) bad++;
                checks++; if (bad !== 0) begin errors++; $display("FAIL rand_victim_block @%h got %0d wrong bytes want 0", e.wr_addr, bad); end
            end
            model_apply(a, we, d);
            last_rd = exp_d;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_miss();
        test_hit_read();
        test_write_hit();
        test_dirty_miss();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache for 32-bit CPU word accesses.
- Sits directly upstream of main_memory and drives its block read/write port.
- Misses fetch whole 32-byte blocks. Dirty victims are written back as whole blocks before refill.
- Relies on main_memory semantics: combinational block read while read enable is high; block write committed at the clk edge while write enable is high.

Parameters:
- MEM_BYTES, 65536, byte-addressable memory size; ADDR_W = $clog2(MEM_BYTES) = 16.
- BLOCK_BYTES, 32, line size; must match main_memory; OFF_W = 5.
- NUM_LINES, 8, number of cache lines (power of 2); IDX_W = 3; TAG_W = ADDR_W - IDX_W - OFF_W = 8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write word, 0 = read word.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored (word-aligned).
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; registered.
- cpu_ready  out  1  one-cycle completion pulse; registered.
- mem_read_en  out  1  to main_memory read_block_en.
- mem_write_en  out  1  to main_memory write_block_en.
- mem_addr  out  ADDR_W  block-aligned address (low OFF_W bits = 0).
- mem_write_block  out  8*BLOCK_BYTES  victim line data.
- mem_read_block  in  8*BLOCK_BYTES  fill data from main_memory.

Behaviour:
- Address split:
  - tag = addr[15:8], index = addr[7:5], word = addr[4:2].
  - Word w occupies line bits [w*32 +: 32]; byte i of a line is bits [i*8 +: 8], matching memory byte order.
- Storage per line: valid, dirty, tag, 256-bit data.
  - Reset clears every valid and dirty bit.
  - Tag and data arrays are not reset.
- Reset values: state = IDLE, cpu_ready = 0, cpu_rdata = 0, all mem_* outputs = 0.
- mem_* outputs are combinational from state and registered request fields only. Outside WRITEBACK/ALLOCATE they are all 0.
- FSM:
  - IDLE: if cpu_req, latch addr/we/wdata → COMPARE. cpu_req is ignored in all other states; the request fields are not re-sampled.
  - COMPARE, hit (valid && tag match):
    - Read: cpu_rdata <= selected word.
    - Write: the selected word is replaced by wdata and dirty <= 1.
    - In both cases cpu_ready <= 1 for one cycle → IDLE.
  - COMPARE, miss: valid && dirty → WRITEBACK; otherwise → ALLOCATE.
  - WRITEBACK (1 cycle): mem_write_en = 1, mem_addr = {old_tag, index, 5'b0}, mem_write_block = line data → ALLOCATE.
  - ALLOCATE (1 cycle): mem_read_en = 1, mem_addr = {tag, index, 5'b0}. At the edge: line data <= mem_read_block, tag <= req tag, valid <= 1, dirty <= 0 → COMPARE. The second COMPARE always hits.
- Latency, counted from the edge N that accepts a request in IDLE:
  - Hit: cpu_ready high after edge N+1.
  - Clean miss: cpu_ready high after edge N+3.
  - Dirty miss: cpu_ready high after edge N+4.
- cpu_rdata holds its last read result through writes and idle cycles.
- Back-to-back: the cycle with cpu_ready = 1 is in IDLE, so a cpu_req high in that cycle is accepted on the next edge.
- Exactly one mem_read_en pulse per miss; exactly one mem_write_en pulse per dirty miss; no memory activity on hits.
- Reset mid-operation: outputs drop immediately (async), so no memory write is committed on an edge while rst_n = 0.
  - An in-flight request is dropped without cpu_ready.
  - All lines become invalid. Dirty data is lost by design.

Test Plan:
- Reset, memory word 0x0040 = 0xDEADBEEF, read 0x0040:
  - one mem_read_en pulse with mem_addr = 0x0040, no mem_write_en;
  - cpu_ready after edge N+3 with cpu_rdata = 0xDEADBEEF.
- Then read 0x0044 → hit, no mem_* activity, cpu_ready after N+1, data = memory word at 0x0044.
- Write 0x0048 = 0x12345678:
  - hit, cpu_ready after N+1, memory bytes 0x48..0x4B unchanged;
  - a following read of 0x0048 returns 0x12345678.
- Read 0x0148 (same index 2, tag 0x01) → dirty miss:
  - WRITEBACK pulse with mem_addr = 0x0040, then ALLOCATE with mem_addr = 0x0140;
  - memory bytes 0x48..0x4B = 78 56 34 12;
  - cpu_ready after N+4.
- Back-to-back: hold cpu_req high continuously with alternating addresses 0x0044 and 0x0048 → each hit completes every 2 cycles and cpu_rdata tracks each address.
- Assert rst_n = 0 during ALLOCATE → mem_read_en, cpu_ready and state clear immediately. After release, read 0x0044 misses again (mem_read_en pulse at 0x0040).
